// File: rtl/gc_poll_scheduler.sv
// gc_poll_scheduler: per-frame GameCube controller poll sequencer.
// After each accepted USB start-of-frame it waits POLL_DELAY cycles, then
// starts ports 0..3 strictly one at a time. It collects connected/timeout
// results and hands a frame summary to the report builder.
// Optional build macro GC_SCHED_SKIP_ABSENT_EN: ports that were absent in the
// last completed frame are only re-probed when the frame counter wraps to 0.
module gc_poll_scheduler #(
   parameter int unsigned POLL_DELAY     = 600,
   parameter int unsigned TIMEOUT        = 24000,
   parameter int unsigned PROBE_INTERVAL = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       sof,
   input  logic [3:0] port_en,
   input  logic [3:0] port_done,
   input  logic [3:0] port_present,
   input  logic       report_ready,
   output logic [3:0] port_start,
   output logic       report_valid,
   output logic [3:0] connect_mask,
   output logic [3:0] timeout_flags,
   output logic       busy,
   output logic       overrun
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned FC_W  = $clog2(PROBE_INTERVAL);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DELAY,
      ST_START,
      ST_WAIT,
      ST_NEXT,
      ST_REPORT
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        idx_q;
   logic [FC_W-1:0]   frame_q;
   logic [3:0]        work_mask_q;
   logic [3:0]        work_flags_q;
   logic [3:0]        port_start_q;
   logic              report_valid_q;
   logic [3:0]        connect_mask_q;
   logic [3:0]        timeout_flags_q;
   logic              busy_q;
   logic              overrun_q;
   logic              skip_c;

   // Decide whether the current port is left out of this frame's polling.
`ifdef GC_SCHED_SKIP_ABSENT_EN
   assign skip_c = !connect_mask_q[idx_q] && (frame_q != FC_W'(0));
`else
   assign skip_c = 1'b0;
`endif

   // Frame sequencer: state, counters, working results and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         idx_q           <= '0;
         frame_q         <= '0;
         work_mask_q     <= '0;
         work_flags_q    <= '0;
         port_start_q    <= '0;
         report_valid_q  <= 1'b0;
         connect_mask_q  <= '0;
         timeout_flags_q <= '0;
         busy_q          <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         port_start_q <= '0;
         overrun_q    <= sof && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (sof) begin
                  state_q      <= ST_DELAY;
                  cnt_q        <= CNT_W'(POLL_DELAY - 1);
                  frame_q      <= frame_q + FC_W'(1);
                  work_mask_q  <= '0;
                  work_flags_q <= '0;
                  idx_q        <= '0;
                  busy_q       <= 1'b1;
               end
            end
            ST_DELAY: begin
               if (cnt_q == '0) begin
                  state_q <= ST_START;
                  idx_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_START: begin
               if (!port_en[idx_q] || skip_c) begin
                  state_q <= ST_NEXT;
               end else begin
                  port_start_q <= 4'b0001 << idx_q;
                  cnt_q        <= CNT_W'(TIMEOUT - 1);
                  state_q      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (port_done[idx_q]) begin
                  work_mask_q[idx_q] <= port_present[idx_q];
                  state_q            <= ST_NEXT;
               end else if (cnt_q == '0) begin
                  work_mask_q[idx_q]  <= 1'b0;
                  work_flags_q[idx_q] <= 1'b1;
                  state_q             <= ST_NEXT;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ST_NEXT: begin
               if (idx_q == 2'd3) begin
                  state_q         <= ST_REPORT;
                  connect_mask_q  <= work_mask_q;
                  timeout_flags_q <= work_flags_q;
                  report_valid_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= ST_START;
               end
            end
            ST_REPORT: begin
               if (report_ready) begin
                  state_q        <= ST_IDLE;
                  report_valid_q <= 1'b0;
                  busy_q         <= 1'b0;
                  idx_q          <= '0;
               end
            end
            default: begin
               state_q        <= ST_IDLE;
               report_valid_q <= 1'b0;
               busy_q         <= 1'b0;
            end
         endcase
      end
   end

   assign port_start    = port_start_q;
   assign report_valid  = report_valid_q;
   assign connect_mask  = connect_mask_q;
   assign timeout_flags = timeout_flags_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;

endmodule
